dac_out: RTL and testbench
==========================

Name: dac_out

Overview:
- Final output stage of a generator channel. Consumes the generator's processed sample stream (after gain, offset and enable) and drives one DAC sample per clock.
- Never starves the DAC:
  - Underflows are covered by holding the last sample or outputting an idle value.
  - Each underflow is counted and signalled.
- Applies a programmable slew-rate limit, so enable/disable, burst end and underflow transitions do not produce full-scale steps.
- Converts two's-complement samples to the DAC's offset-binary code.

Parameters:
DW, 14, DAC/sample width in bits; stream data type is signed logic [DW-1:0], DN=1
CWU, 16, width of saturating underflow counter

Ports:
clk  in  1  clock; also clocks the sti interface (sti.ACLK driven from the same net)
rstn  in  1  reset, asynchronous, active-low
sti  axi4_stream_if.d  DN=1, DT=signed [DW-1:0]  sample input (TDATA, TVALID, TLAST, TREADY)
dac_dat  out  DW  DAC code, offset binary, registered
cfg_ena  in  1  output enable (0: ramp to idle, refuse input)
cfg_und  in  1  underflow policy: 0 hold last accepted sample, 1 go to cfg_idl
cfg_idl  in  DW  idle value, two's complement
cfg_slw  in  DW  max output change per clock, unsigned; 0 = unlimited
ctl_clr  in  1  single-cycle clear of sts_und
sts_und  out  CWU  underflow count, saturating
sts_set  out  1  1 when current output equals target (settled)
evo_und  out  1  one-cycle pulse on entering the UND state

Behaviour:
Reset (rstn low, asynchronous):
- state=OFF, target=0, cur=0, dac_dat=2^(DW-1) (midscale, 14'h2000).
- sts_und=0, evo_und=0, sts_set=1.

Handshake:
- sti.TREADY = cfg_ena & (state!=OFF), combinational. Never depends on TVALID.
- Transfer happens when TVALID & TREADY.

States:
- OFF:
  - target=cfg_idl.
  - cfg_ena=1 moves to END on the next cycle (END is an armed state that waits for data without counting underflow).
- RUN:
  - On transfer: target=TDATA. If TLAST is also set, go to END.
  - Without TVALID: go to UND, pulse evo_und, increment sts_und.
- UND:
  - target = cfg_und ? cfg_idl : held sample.
  - Transfer returns to RUN, loading target that cycle. No further counting while in UND.
- END:
  - target=cfg_idl.
  - TVALID low is not an underflow.
  - Transfer goes to RUN (or stays in END if TLAST), loading target.
- Any state: cfg_ena=0 forces OFF on the next clock. A transfer in that same cycle is still accepted and loaded.

Slew limiter (one register stage):
- diff = target - cur, computed in DW+1 bits signed.
- If cfg_slw==0 or |diff|<=cfg_slw: cur<=target. Otherwise cur <= cur + sign(diff)*cfg_slw.
- No overflow is possible: intermediate values stay between cur and target.

Output register:
- dac_dat <= {~cur[DW-1], cur[DW-2:0]}.
- Latency: transfer in cycle N → target valid N+1 → cur N+2 → dac_dat N+3 (unlimited slew).
- sts_set = (cur==target), registered alongside cur.

sts_und:
- Saturates at 2^CWU-1.
- ctl_clr has priority over a simultaneous increment; the result is 0.

Mid-operation changes:
- A cfg_slw change takes effect on the next step.
- A cfg_idl change while in OFF/END/UND(policy 1) retargets immediately.

Decomposition:
- Package dac_out_pkg:
  - state enum typedef (OFF, RUN, UND, END), 2 bits.
  - Function to_offbin(sample) for the two's-complement to offset-binary conversion.
- One sub-module, slew_lim: target/cur registers, diff arithmetic, sts_set. Parameter DW; cfg_slw input.
- Top: FSM, underflow counter, output register.

Test Plan:
- Reset then cfg_ena=0 → dac_dat=14'h2000, TREADY=0, sts_und=0.
- cfg_ena=1, cfg_slw=0, stream 100, -100, 8191 continuous → dac_dat 14'h2064, 14'h1F9C, 14'h3FFF, each 3 cycles after its transfer; sts_und=0.
- Stream 1000 then TVALID low 5 cycles, cfg_und=0 → output holds 1000, sts_und=1, single evo_und pulse. Repeat with cfg_und=1, cfg_idl=0 → output returns to midscale.
- Burst ending with TLAST on sample 500, then TVALID low 20 cycles, cfg_idl=0 → output goes to 0, sts_und unchanged, no evo_und.
- cfg_slw=100, output settled at 0, transfer 1000 → output steps 100,200,…,1000 over 10 cycles. sts_set=0 until cur reaches 1000, then 1. Then cfg_ena=0 → ramps down to cfg_idl at the same rate.
- Force 2^CWU+3 underflow events → sts_und saturates at 2^CWU-1. ctl_clr coinciding with an underflow → 0. Assert rstn low mid-ramp → immediate midscale and state OFF.

Source files
------------

// File: rtl/dac_out_pkg.sv
// Shared types and helpers for the DAC output stage.
package dac_out_pkg;

   typedef enum logic [1:0] {
      OFF = 2'd0,
      RUN = 2'd1,
      UND = 2'd2,
      END = 2'd3
   } state_t;

   // Flipping the sign bit maps two's complement onto offset binary.
   function automatic logic [31:0] to_offbin(input logic [31:0] s,
                                             input int unsigned w);
      return s ^ (32'd1 << (w - 1));
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Single-lane AXI4-Stream bundle carrying signed samples.
interface axi4_stream_if #(
   parameter int DW = 14
) (
   input logic ACLK
);

   logic signed [DW-1:0] TDATA;
   logic                 TVALID;
   logic                 TLAST;
   logic                 TREADY;

   modport s (input ACLK, input TREADY,
              output TDATA, output TVALID, output TLAST);
   modport d (input ACLK, input TDATA, input TVALID, input TLAST,
              output TREADY);

endinterface

// File: rtl/slew_lim.sv
// Target/current registers with a per-clock step limit.
module slew_lim #(
   parameter int DW = 14
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic signed [DW-1:0] tgt_nxt,
   input  logic        [DW-1:0] cfg_slw,
   output logic signed [DW-1:0] cur,
   output logic                 set
);

   logic signed [DW-1:0] tgt;
   logic signed [DW-1:0] cur_nxt;
   logic        [DW:0]   dif;
   logic        [DW:0]   mag;
   logic        [DW:0]   stp;
   logic        [DW:0]   sum;

   always_comb begin
      dif = {tgt[DW-1], tgt} - {cur[DW-1], cur};
      mag = dif[DW] ? (~dif + 1'b1) : dif;
      stp = dif[DW] ? (~{1'b0, cfg_slw} + 1'b1) : {1'b0, cfg_slw};
      sum = {cur[DW-1], cur} + stp;
      cur_nxt = tgt;
      if (cfg_slw != '0 && mag > {1'b0, cfg_slw})
         cur_nxt = sum[DW-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tgt <= '0;
         cur <= '0;
         set <= 1'b1;
      end else begin
         tgt <= tgt_nxt;
         cur <= cur_nxt;
         set <= (cur_nxt == tgt_nxt);
      end
   end

endmodule

// File: rtl/dac_out.sv
// Generator channel output stage: stream FSM, underflow
// accounting, slew limiting and offset-binary DAC register.
module dac_out
   import dac_out_pkg::*;
#(
   parameter int DW  = 14,
   parameter int CWU = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   axi4_stream_if.d             sti,
   output logic        [DW-1:0] dac_dat,
   input  logic                 cfg_ena,
   input  logic                 cfg_und,
   input  logic signed [DW-1:0] cfg_idl,
   input  logic        [DW-1:0] cfg_slw,
   input  logic                 ctl_clr,
   output logic       [CWU-1:0] sts_und,
   output logic                 sts_set,
   output logic                 evo_und
);

   state_t               state, state_nxt;
   logic                 rdy, xfer, und;
   logic signed [DW-1:0] hld, tgt_nxt, cur;

   assign rdy        = cfg_ena & (state != OFF);
   assign sti.TREADY = rdy;
   assign xfer       = sti.TVALID & rdy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= OFF;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OFF: state_nxt = END;
         RUN: if (xfer) state_nxt = sti.TLAST ? END : RUN;
              else      state_nxt = UND;
         UND,
         END: if (xfer) state_nxt = sti.TLAST ? END : RUN;
         default: state_nxt = OFF;
      endcase
      if (!cfg_ena) state_nxt = OFF;
   end

   always_comb begin
      und     = cfg_ena & (state == RUN) & ~sti.TVALID;
      tgt_nxt = cfg_idl;
      if (xfer) begin
         tgt_nxt = sti.TDATA;
      end else begin
         case (state)
            RUN:     tgt_nxt = hld;
            UND:     tgt_nxt = cfg_und ? cfg_idl : hld;
            default: tgt_nxt = cfg_idl;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hld     <= '0;
         sts_und <= '0;
         evo_und <= 1'b0;
         dac_dat <= {1'b1, {(DW-1){1'b0}}};
      end else begin
         if (xfer) hld <= sti.TDATA;
         if (ctl_clr)
            sts_und <= '0;
         else if (und && sts_und != '1)
            sts_und <= sts_und + 1'b1;
         evo_und <= und;
         dac_dat <= DW'(to_offbin(32'(cur), DW));
      end
   end

   slew_lim #(.DW(DW)) u_slw (
      .clk     (clk),
      .rstn    (rstn),
      .tgt_nxt (tgt_nxt),
      .cfg_slw (cfg_slw),
      .cur     (cur),
      .set     (sts_set)
   );

endmodule

// File: tb/tb_dac_out.sv
// Directed self-checking bench for dac_out.
module tb_dac_out;

   localparam int DW  = 14;
   localparam int CWU = 4;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic        [DW-1:0] dac_dat;
   logic                 cfg_ena, cfg_und, ctl_clr;
   logic signed [DW-1:0] cfg_idl;
   logic        [DW-1:0] cfg_slw;
   logic       [CWU-1:0] sts_und;
   logic                 sts_set, evo_und;

   int checks   = 0;
   int failures = 0;
   int np;

   always #5 clk = ~clk;

   axi4_stream_if #(.DW(DW)) sti (.ACLK(clk));

   dac_out #(.DW(DW), .CWU(CWU)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sti     (sti),
      .dac_dat (dac_dat),
      .cfg_ena (cfg_ena),
      .cfg_und (cfg_und),
      .cfg_idl (cfg_idl),
      .cfg_slw (cfg_slw),
      .ctl_clr (ctl_clr),
      .sts_und (sts_und),
      .sts_set (sts_set),
      .evo_und (evo_und)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit v, input int d, input bit l);
      sti.TVALID = v;
      sti.TDATA  = DW'(d);
      sti.TLAST  = l;
   endtask

   function automatic logic [31:0] ob(input int v);
      return 32'((v + 8192) & 16383);
   endfunction

   initial begin
      rstn = 1'b0; cfg_ena = 1'b0; cfg_und = 1'b0; ctl_clr = 1'b0;
      cfg_idl = '0; cfg_slw = '0;
      drv(0, 0, 0);
      step(); step();
      rstn = 1'b1;
      step();
      chk("rst_dac", 32'(dac_dat), 32'h2000);
      chk("rst_rdy", 32'(sti.TREADY), 0);
      chk("rst_und", 32'(sts_und), 0);
      chk("rst_set", 32'(sts_set), 1);

      // continuous stream, unlimited slew
      cfg_ena = 1'b1;
      step();
      chk("arm_rdy", 32'(sti.TREADY), 1);
      drv(1, 100, 0);  step();
      drv(1, -100, 0); step();
      drv(1, 8191, 1); step();
      chk("s100", 32'(dac_dat), 32'h2064);
      drv(0, 0, 0);    step();
      chk("sm100", 32'(dac_dat), 32'h1F9C);
      step();
      chk("s8191", 32'(dac_dat), 32'h3FFF);
      step(); step();
      chk("end_idl", 32'(dac_dat), 32'h2000);
      chk("s_und0", 32'(sts_und), 0);

      // underflow, hold policy
      drv(1, 1000, 0); step();
      drv(0, 0, 0);
      np = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         np += int'(evo_und);
      end
      chk("hold_dac", 32'(dac_dat), ob(1000));
      chk("hold_und", 32'(sts_und), 1);
      chk("hold_evo", 32'(np), 1);

      // underflow, idle policy
      cfg_und = 1'b1;
      drv(1, 1000, 0); step();
      drv(0, 0, 0);
      np = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         np += int'(evo_und);
      end
      chk("idl_dac", 32'(dac_dat), 32'h2000);
      chk("idl_und", 32'(sts_und), 2);
      chk("idl_evo", 32'(np), 1);

      // burst end is not an underflow
      cfg_und = 1'b0;
      drv(1, 200, 0); step();
      drv(1, 500, 1); step();
      drv(0, 0, 0);
      np = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         np += int'(evo_und);
         if (i == 1) chk("last500", 32'(dac_dat), ob(500));
      end
      chk("brst_dac", 32'(dac_dat), 32'h2000);
      chk("brst_und", 32'(sts_und), 2);
      chk("brst_evo", 32'(np), 0);

      // slew up 0 -> 1000 at 100 per clock
      cfg_slw = 14'd100;
      drv(1, 1000, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k >= 3)
            chk($sformatf("up%0d", k), 32'(dac_dat), ob((k - 2) * 100));
         chk($sformatf("set%0d", k), 32'(sts_set), (k >= 11) ? 1 : 0);
      end

      // disable ramps back to idle
      cfg_ena = 1'b0;
      drv(0, 0, 0);
      for (int m = 1; m <= 14; m++) begin
         step();
         if (m >= 4)
            chk($sformatf("dn%0d", m), 32'(dac_dat),
                ob((m >= 13) ? 0 : 1000 - 100 * (m - 3)));
      end
      chk("dn_und", 32'(sts_und), 2);

      // counter saturation
      cfg_slw = '0;
      cfg_ena = 1'b1;
      step();
      for (int i = 0; i < (1 << CWU) + 3; i++) begin
         drv(1, i, 0); step();
         drv(0, 0, 0); step();
      end
      chk("sat", 32'(sts_und), 32'((1 << CWU) - 1));

      // clear wins over simultaneous increment
      drv(1, 7, 0); step();
      drv(0, 0, 0);
      ctl_clr = 1'b1;
      step();
      ctl_clr = 1'b0;
      chk("clr_und", 32'(sts_und), 0);
      chk("clr_evo", 32'(evo_und), 1);
      drv(1, 8, 0); step();
      drv(0, 0, 0); step();
      chk("inc_after", 32'(sts_und), 1);

      // asynchronous reset mid-ramp
      drv(1, 1000, 0);
      for (int i = 0; i < 5; i++) step();
      cfg_slw = 14'd100;
      drv(1, -1000, 0);
      for (int i = 0; i < 4; i++) step();
      chk("ramp_mid", 32'(dac_dat), ob(800));
      #2;
      rstn = 1'b0;
      #1;
      chk("ar_dac", 32'(dac_dat), 32'h2000);
      chk("ar_rdy", 32'(sti.TREADY), 0);
      chk("ar_und", 32'(sts_und), 0);
      chk("ar_set", 32'(sts_set), 1);
      step();
      rstn = 1'b1;
      drv(0, 0, 0);
      step();
      chk("rearm_rdy", 32'(sti.TREADY), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
